// File: rtl/onehot_encoder_pipe.sv
// Registered WIDTH-to-index encoder with valid/ready handshake.
// Selects the highest set bit (MODE 0) or the first set bit at/after a rotating pointer (MODE 1).
module onehot_encoder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_any,
  output logic             out_multi
);

  if (IDX_W != $clog2(WIDTH)) begin : g_bad_idx_w
    $error("onehot_encoder_pipe: IDX_W must equal clog2(WIDTH)");
  end
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("onehot_encoder_pipe: WIDTH must be within 2..64");
  end

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] rr_off;
  logic [IDX_W:0]   rr_sum;
  logic [WIDTH-1:0] rot;
  logic             rr_found;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             sel_multi;
  logic             accept;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign sel_any   = |in_vec;
  assign sel_multi = (in_vec & (in_vec - WIDTH'(1))) != '0;

  // Fixed priority: later (higher) bits overwrite earlier ones.
  always_comb begin
    hi_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_vec[i]) hi_idx = IDX_W'(i);
    end
  end

  // Round-robin: rotate so ptr lands on bit 0, find the lowest set bit,
  // then add ptr back with an explicit wrap so non-power-of-2 WIDTH works.
  always_comb begin
    rot      = (in_vec >> ptr) | (in_vec << (WIDTH - int'(ptr)));
    rr_found = 1'b0;
    rr_off   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!rr_found && rot[i]) begin
        rr_found = 1'b1;
        rr_off   = IDX_W'(i);
      end
    end
    rr_sum = {1'b0, ptr} + {1'b0, rr_off};
    if (rr_sum >= (IDX_W + 1)'(WIDTH)) rr_sum = rr_sum - (IDX_W + 1)'(WIDTH);
    rr_idx = sel_any ? rr_sum[IDX_W-1:0] : '0;
  end

  always_comb begin
    sel_idx  = (MODE == 1) ? rr_idx : hi_idx;
    ptr_next = (sel_idx == LAST) ? '0 : sel_idx + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_any   <= 1'b0;
      out_multi <= 1'b0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_idx   <= sel_idx;
        out_any   <= sel_any;
        out_multi <= sel_multi;
        if (MODE == 1 && sel_any) ptr <= ptr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Scoreboard bench for onehot_encoder_pipe: three instances (fixed W32, RR W8, RR W5)
// checked every cycle against a behavioural model of the selection rules.
module tb_onehot_encoder_pipe;

  typedef struct packed {
    logic [4:0] idx;
    logic       any;
    logic       multi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ivalid [3];
  logic [31:0] ivec   [3];
  logic        ordy   [3];
  logic        irdy   [3];
  logic        ovld   [3];
  logic [4:0]  oidx   [3];
  logic        oany   [3];
  logic        omul   [3];
  logic [2:0]  idx1, idx2;

  int unsigned w_of    [3] = '{32, 8, 5};
  int unsigned mode_of [3] = '{0, 1, 1};
  int unsigned ptr_m   [3] = '{0, 0, 0};
  exp_t        sb [3][$];
  logic        prev_rst = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  onehot_encoder_pipe #(.WIDTH(32), .IDX_W(5), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(ivalid[0]), .in_ready(irdy[0]), .in_vec(ivec[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .out_idx(oidx[0]), .out_any(oany[0]), .out_multi(omul[0])
  );

  onehot_encoder_pipe #(.WIDTH(8), .IDX_W(3), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(ivalid[1]), .in_ready(irdy[1]), .in_vec(ivec[1][7:0]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .out_idx(idx1), .out_any(oany[1]), .out_multi(omul[1])
  );

  onehot_encoder_pipe #(.WIDTH(5), .IDX_W(3), .MODE(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(ivalid[2]), .in_ready(irdy[2]), .in_vec(ivec[2][4:0]),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .out_idx(idx2), .out_any(oany[2]), .out_multi(omul[2])
  );

  assign oidx[1] = {2'b00, idx1};
  assign oidx[2] = {2'b00, idx2};

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s[dut%0d]: got %0h want %0h", tag, d, obs, expv);
    end
  endtask

  function automatic exp_t model(input int unsigned w, input int unsigned mode,
                                 input logic [31:0] v, input int unsigned p);
    exp_t        e;
    logic [63:0] mask;
    logic [31:0] m;
    bit          found;
    int unsigned j;
    e     = '0;
    found = 1'b0;
    mask  = (64'h1 << w) - 64'h1;
    m     = v & mask[31:0];
    e.any   = |m;
    e.multi = $countones(m) > 1;
    for (int unsigned k = 0; k < w; k++) begin
      if (mode == 0) begin
        if (m[k]) e.idx = 5'(k);
      end else begin
        j = (p + k) % w;
        if (!found && m[j]) begin
          found = 1'b1;
          e.idx = 5'(j);
        end
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] dut_ptr(input int d);
    case (d)
      0:       return 32'(u0.ptr);
      1:       return 32'(u1.ptr);
      default: return 32'(u2.ptr);
    endcase
  endfunction

  task automatic check_dut(input int d);
    logic exp_valid;
    logic exp_rdy;
    exp_t e;
    exp_valid = sb[d].size() != 0;
    exp_rdy   = !rst && (!exp_valid || ordy[d]);
    chk("in_ready", d, 32'(irdy[d]), 32'(exp_rdy));
    chk("out_valid", d, 32'(ovld[d]), 32'(exp_valid));
    chk("ptr", d, dut_ptr(d), ptr_m[d]);
    if (prev_rst) begin
      chk("rst_idx", d, 32'(oidx[d]), 32'd0);
      chk("rst_any", d, 32'(oany[d]), 32'd0);
      chk("rst_multi", d, 32'(omul[d]), 32'd0);
    end
    if (exp_valid) begin
      e = sb[d][0];
      chk("out_idx", d, 32'(oidx[d]), 32'(e.idx));
      chk("out_any", d, 32'(oany[d]), 32'(e.any));
      chk("out_multi", d, 32'(omul[d]), 32'(e.multi));
    end
    if (rst) begin
      sb[d].delete();
      ptr_m[d] = 0;
    end else begin
      if (exp_valid && ordy[d]) void'(sb[d].pop_front());
      if (ivalid[d] && exp_rdy) begin
        e = model(w_of[d], mode_of[d], ivec[d], ptr_m[d]);
        sb[d].push_back(e);
        if (mode_of[d] == 1 && e.any) ptr_m[d] = (32'(e.idx) + 1) % w_of[d];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_dut(d);
    prev_rst = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] vec, input logic r);
    ivalid[d] = v;
    ivec[d]   = vec;
    ordy[d]   = r;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 32'd0, 1'b1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // one-hot walk, back-to-back
    for (int k = 0; k < 32; k++) begin
      drive(0, 1'b1, 32'h1 << k, 1'b1);
      step();
    end
    // fixed priority on multi-hot, then empty
    drive(0, 1'b1, 32'h0000_8011, 1'b1);
    step();
    drive(0, 1'b1, 32'h0, 1'b1);
    step();
    drive(0, 1'b0, 32'h0, 1'b1);
    step();

    // backpressure
    drive(0, 1'b1, 32'h0000_0100, 1'b1);
    step();
    drive(0, 1'b1, 32'h0000_0001, 1'b0);
    step();
    step();
    step();
    drive(0, 1'b1, 32'h0000_0001, 1'b1);
    step();
    drive(0, 1'b0, 32'h0, 1'b1);
    step();
    step();

    // round-robin rotation, WIDTH=8
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b1, 32'h89, 1'b1);
      step();
    end
    drive(1, 1'b1, 32'h00, 1'b1);
    step();
    drive(1, 1'b1, 32'h03, 1'b1);
    step();
    drive(1, 1'b0, 32'h00, 1'b1);
    step();

    // round-robin, WIDTH=5
    drive(2, 1'b1, 32'h10, 1'b1);
    step();
    step();
    drive(2, 1'b1, 32'h11, 1'b1);
    step();
    drive(2, 1'b1, 32'h03, 1'b1);
    step();
    drive(2, 1'b0, 32'h00, 1'b1);
    step();

    // reset mid-operation with a held result and ptr=3
    drive(1, 1'b1, 32'h04, 1'b1);
    step();
    drive(1, 1'b0, 32'h00, 1'b0);
    step();
    step();
    rst = 1'b1;
    drive(1, 1'b0, 32'h00, 1'b1);
    step();
    rst = 1'b0;
    step();
    drive(1, 1'b1, 32'hFF, 1'b1);
    step();
    drive(1, 1'b0, 32'h00, 1'b1);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
- Parametrised, registered successor to the combinational 32-to-5 one-hot encoder used by the pipeline's select/forwarding logic.
- Takes a WIDTH-bit request vector and returns the binary index of one set bit, chosen by one of two modes:
  - fixed priority, where the highest set bit wins;
  - round-robin, where a rotating start pointer sets the search order.
- Adds valid/ready handshaking, a single-entry output register, an "any bit set" flag and a multi-hot error flag.
- Sits between hazard/arbitration logic and any consumer that can stall.

Parameters:
- WIDTH, 32, number of request bits; legal range 2..64, power of two not required.
- IDX_W, 5, index width; must equal ceil(log2(WIDTH)).
- MODE, 0, selection mode: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_vec is valid this cycle.
- in_ready  out  1  block can accept a vector this cycle.
- in_vec  in  WIDTH  request vector.
- out_valid  out  1  registered result is valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_idx  out  IDX_W  index of the selected bit.
- out_any  out  1  at least one bit was set in the accepted vector.
- out_multi  out  1  more than one bit was set (one-hot violation).

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0, out_idx=0, out_any=0, out_multi=0.
  - Round-robin pointer ptr=0.
  - Any pending result is discarded, even if out_ready is asserted in the same cycle.
- in_ready = !out_valid || out_ready. It is combinational, and it is low while rst=1.
- Input accept: in_valid && in_ready at a rising edge. The result appears registered on the next cycle, so latency = 1 cycle. Full throughput is one result per cycle when out_ready is held high.
- Backpressure: while out_valid && !out_ready, out_idx, out_any and out_multi must hold stable. in_vec is ignored during this time and is not accepted.
- Output retire: out_valid && out_ready.
  - If an accept happens in the same cycle, out_valid stays 1 and the new result loads.
  - Otherwise out_valid goes to 0. The data outputs keep their last value and are don't-care.
- out_any = OR of all bits of in_vec.
- out_multi = 1 iff popcount(in_vec) >= 2.
- Empty vector (all zeros): still produces an output beat with out_any=0, out_idx=0, out_multi=0.
- MODE 0 (fixed priority):
  - out_idx = highest set bit position.
  - For one-hot input this matches the existing 32-to-5 encoder exactly.
  - ptr is unused and stays 0.
- MODE 1 (round-robin):
  - Search starts at position ptr and goes upward, wrapping from WIDTH-1 to 0.
  - out_idx = first set bit found.
  - On an accept with out_any=1: ptr <= (out_idx+1), wrapping to 0 when out_idx = WIDTH-1. This wrap is explicit, so non-power-of-2 WIDTH works.
  - On an accept with an empty vector: ptr is unchanged.
  - ptr never updates without an accept.
- IDX_W mismatch with WIDTH: elaboration-time error (assertion); no runtime behaviour is defined.
- No combinational path from in_vec to any out_* port. The only combinational path is out_ready -> in_ready.

Test Plan:
- Reset and one-hot equivalence, MODE 0, WIDTH=32. Reset for 2 cycles, then feed in_vec=1<<k for k=0..31 back-to-back with out_ready=1.
  -> out_idx=k one cycle after each accept; out_any=1; out_multi=0; out_valid continuous for 32 cycles.
- Fixed priority on multi-hot, MODE 0, in_vec=32'h0000_8011.
  -> out_idx=15, out_any=1, out_multi=1.
  - Then in_vec=0 -> out_idx=0, out_any=0, out_multi=0.
- Backpressure: accept in_vec=32'h0000_0100, hold out_ready=0 for 3 cycles while presenting in_vec=32'h0000_0001 with in_valid=1.
  -> out_idx=8 is held stable and in_ready=0 throughout.
  - Raise out_ready -> in_ready=1, 32'h0000_0001 is accepted, and out_idx=0 follows on the next cycle.
- Round-robin rotation, MODE 1, WIDTH=8. Feed in_vec=8'b1000_1001 four times with out_ready=1.
  -> out_idx sequence is 0, 3, 7, 0; ptr goes 1, 4, 0, 1.
  - Then in_vec=0 -> out_any=0 and ptr stays at 1.
- Round-robin with non-power-of-2 width, MODE 1, WIDTH=5, IDX_W=3. Feed in_vec=5'b10000 twice.
  -> out_idx=4 both times; ptr wraps to 0 with no illegal values 5..7.
- Reset mid-operation: with out_valid=1, out_ready=0 and ptr=3 (MODE 1), assert rst for 1 cycle.
  -> next cycle out_valid=0 and all outputs are 0.
  - First post-reset vector 8'b1111_1111 -> out_idx=0.
